pwm_capture: RTL and testbench
==============================

# pwm_capture

PWM capture block, the receive-side counterpart of the team's PWM generator. It samples an asynchronous PWM input and measures the high time and period of each cycle in prescaled ticks. It publishes each completed measurement with a one-cycle valid strobe and flags a stuck input (0 % or 100 % duty) after a timeout. It sits between a pin, such as a servo or fan tach or a loopback of a generator output, and a memory-mapped register front end.

## Interface
- PRESCALE, 64, clock cycles per measurement tick (≥ 2)
- WIDTH, 10, width of tick counters and measurement outputs
- TIMEOUT, 1023, ticks without any input edge before declaring stuck (1..65535)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- pwm_in  in  1  asynchronous PWM input
- high_ticks  out  WIDTH  high time of last completed cycle, in ticks
- period_ticks  out  WIDTH  period of last completed cycle, in ticks
- sample_valid  out  1  one-cycle strobe when high_ticks/period_ticks update
- level_stuck  out  1  no edge seen for TIMEOUT ticks
- stuck_level  out  1  synchronized input level when level_stuck was set

## Operation
- pwm_in passes through a 2-flop synchronizer, then a registered copy for edge detect. rise = sync & ~prev; fall = ~sync & prev.
- Prescaler counts 0..PRESCALE-1. tick asserts when prescaler == PRESCALE-1. The prescaler clears to 0 on every rise.
- high_cnt and period_cnt (WIDTH bits) increment on tick and saturate at 2^WIDTH-1, with no wrap. idle_cnt (16 bits) increments on tick, saturates, and clears on any rise or fall.
- States:
  - WAIT_RISE (reset state): discard partial cycle. On rise: clear high_cnt and period_cnt, go to HIGH.
  - HIGH: on fall, latch high_cnt into hold_high and go to LOW.
  - LOW: on rise, set high_ticks ← hold_high, set period_ticks ← period_cnt, pulse sample_valid, clear high_cnt and period_cnt, clear level_stuck, stay measuring in HIGH.
- high_cnt counts only in HIGH. period_cnt counts in HIGH and LOW.
- Timeout: when idle_cnt reaches TIMEOUT in any state, set level_stuck=1 and stuck_level=sync, then go to WAIT_RISE. high_ticks and period_ticks hold their last values.
- level_stuck clears only on the next sample_valid or on reset.
- Simultaneous events:
  - rise and tick in the same cycle: the tick is not counted in the completing cycle, and the new cycle starts at 0.
  - edge and timeout in the same cycle: the edge wins, idle_cnt clears, and no stuck flag is set.
- Reset mid-measurement: all state is discarded. The first rise after reset starts a measurement and does not publish.

## Timing
- Reset values: high_ticks=0, period_ticks=0, sample_valid=0, level_stuck=0, stuck_level=0, state=WAIT_RISE, all counters 0.
- Latency is 3 cycles from a pwm_in transition (first sampling edge) to the rise or fall internal pulse.
- Publish latency: high_ticks, period_ticks and sample_valid are registered. They change and strobe on the cycle after the internal rise, 4 cycles after the pwm_in transition.
- sample_valid is high for exactly 1 cycle per completed period, and is never asserted back-to-back.
- Both edges see identical synchronizer delay, so for inputs synchronous to clk:
  - period_ticks = min(floor(period_cycles/PRESCALE), 2^WIDTH-1)
  - high_ticks = min(floor(high_cycles/PRESCALE), 2^WIDTH-1)
- level_stuck sets TIMEOUT·PRESCALE cycles (±PRESCALE) after the last edge.
- Minimum resolvable pulse width is 1 clk cycle. A high time shorter than PRESCALE reports high_ticks=0 but still publishes.

## Test plan
- Nominal duty. Setup: PRESCALE=4, WIDTH=10, TIMEOUT=100. Stimulus: pwm_in high 40 / low 60 cycles, repeated. Required response:
  - no strobe on the first rise;
  - each later rise gives high_ticks=10, period_ticks=25, and a single 1-cycle sample_valid 4 cycles after the rise.
- Stuck low. Stimulus: after two valid periods, hold pwm_in=0. Required response:
  - level_stuck=1 and stuck_level=0 about 400 cycles after the last fall;
  - outputs keep 10/25.
  - Then resume the waveform: the first rise starts a measurement without publishing, the second rise publishes 10/25, and level_stuck clears on that strobe.
- Stuck high. Stimulus: hold pwm_in=1 after a rise. Required response: level_stuck=1 and stuck_level=1 after about 400 cycles, with no sample_valid.
- Saturation. Setup: WIDTH=4, PRESCALE=4, TIMEOUT=1000. Stimulus: high 80 / low 120 cycles. Required response: high_ticks=15, period_ticks=15.
- Reset mid-HIGH. Stimulus: assert reset for 1 cycle 20 cycles into a high phase. Required response:
  - all outputs are 0 the next cycle;
  - the next rise does not strobe, and the following period reports correctly.
- Narrow pulse. Setup: PRESCALE=4. Stimulus: high 1 cycle, period 40 cycles. Required response: high_ticks=0, period_ticks=10, with sample_valid asserted.

Source files
------------

// File: rtl/pwm_capture_if.sv
// Result bus from pwm_capture toward a register front end.
// Handshake: sample_valid is a one-cycle strobe with no ready; the consumer
// takes high_ticks/period_ticks in the strobe cycle. The values then hold
// until the next strobe. level_stuck/stuck_level are level outputs.
// fsm_state exposes the measurement FSM for checkers.
interface pwm_capture_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] high_ticks;
  logic [WIDTH-1:0] period_ticks;
  logic             sample_valid;
  logic             level_stuck;
  logic             stuck_level;
  logic [1:0]       fsm_state;

  modport master (
    output high_ticks, period_ticks, sample_valid, level_stuck, stuck_level, fsm_state
  );
  modport slave (
    input high_ticks, period_ticks, sample_valid, level_stuck, stuck_level, fsm_state
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures the high time and period of an asynchronous PWM input
// in prescaled ticks, and flags a stuck input after TIMEOUT idle ticks.
module pwm_capture #(
  parameter int PRESCALE = 64,
  parameter int WIDTH    = 10,
  parameter int TIMEOUT  = 1023
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pwm_in,
  pwm_capture_if.master bus
);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [15:0]      IDLE_MAX   = 16'hFFFF;
  localparam logic [15:0]      IDLE_LIMIT = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             sync1, sync2, prev;
  logic             rise, fall;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] high_cnt, period_cnt, hold_high;
  logic [15:0]      idle_cnt;
  logic [WIDTH-1:0] high_ticks_q, period_ticks_q;
  logic             sample_valid_q, level_stuck_q, stuck_level_q;

  logic tick, any_edge, timeout;
  logic publish, restart, latch_high, set_stuck;

  // Synchronizer and edge-detect history. These flops are left out of reset so
  // a reset released while the pin is high does not fabricate a rising edge.
  always_ff @(posedge clk) begin
    sync1 <= pwm_in;
    sync2 <= sync1;
    prev  <= sync2;
  end

  // Registered edge pulses; both edges see the same delay, so durations are exact.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= sync2 & ~prev;
      fall <= ~sync2 & prev;
    end
  end

  // The rise cycle is prescaler slot 0, so a tick never lands on a rise and a
  // cycle of N clocks yields floor(N/PRESCALE) ticks.
  assign tick     = (presc == PRESC_LAST) && !rise;
  assign any_edge = rise | fall;
  assign timeout  = (idle_cnt >= IDLE_LIMIT) && !any_edge;

  // Next-state and control strobes for the measurement FSM.
  always_comb begin
    state_d    = state_q;
    publish    = 1'b0;
    restart    = 1'b0;
    latch_high = 1'b0;
    set_stuck  = 1'b0;
    if (timeout) begin
      set_stuck = 1'b1;
      state_d   = WAIT_RISE;
    end else begin
      case (state_q)
        WAIT_RISE: if (rise) begin
          restart = 1'b1;
          state_d = HIGH;
        end
        HIGH: if (fall) begin
          latch_high = 1'b1;
          state_d    = LOW;
        end
        LOW: if (rise) begin
          publish = 1'b1;
          restart = 1'b1;
          state_d = HIGH;
        end
        default: state_d = WAIT_RISE;
      endcase
    end
  end

  // State register, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= WAIT_RISE;
      presc          <= '0;
      high_cnt       <= '0;
      period_cnt     <= '0;
      hold_high      <= '0;
      idle_cnt       <= '0;
      high_ticks_q   <= '0;
      period_ticks_q <= '0;
      sample_valid_q <= 1'b0;
      level_stuck_q  <= 1'b0;
      stuck_level_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (rise)                     presc <= PW'(1);
      else if (presc == PRESC_LAST) presc <= '0;
      else                          presc <= presc + 1'b1;

      if (restart) begin
        high_cnt   <= '0;
        period_cnt <= '0;
      end else if (tick) begin
        if (state_q == HIGH && high_cnt != CNT_MAX)
          high_cnt <= high_cnt + 1'b1;
        if ((state_q == HIGH || state_q == LOW) && period_cnt != CNT_MAX)
          period_cnt <= period_cnt + 1'b1;
      end

      if (any_edge)                       idle_cnt <= '0;
      else if (tick && idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 16'd1;

      if (latch_high) hold_high <= high_cnt;

      sample_valid_q <= publish;
      if (publish) begin
        high_ticks_q   <= hold_high;
        period_ticks_q <= period_cnt;
        level_stuck_q  <= 1'b0;
      end else if (set_stuck) begin
        level_stuck_q <= 1'b1;
        stuck_level_q <= sync2;
      end
    end
  end

  assign bus.high_ticks   = high_ticks_q;
  assign bus.period_ticks = period_ticks_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.level_stuck  = level_stuck_q;
  assign bus.stuck_level  = stuck_level_q;
  assign bus.fsm_state    = state_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: a nominal-config instance (A) and a narrow-width
// instance (B). Expected measurements come from the driven waveform itself:
// every rise after an armed rise completes a cycle of floor(len/PRESCALE)
// ticks, saturated, published 4 clocks after the pin transition.
module tb_pwm_capture;
  localparam int PS = 4;
  localparam int WA = 10;
  localparam int TA = 100;
  localparam int WB = 4;
  localparam int TB = 1000;
  localparam int W  = 64;

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, rst_b, pwm_a, pwm_b;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pwm_capture_if #(.WIDTH(WA)) bus_a ();
  pwm_capture_if #(.WIDTH(WB)) bus_b ();

  pwm_capture #(.PRESCALE(PS), .WIDTH(WA), .TIMEOUT(TA)) dut_a (
    .clk(clk), .reset(rst_a), .pwm_in(pwm_a), .bus(bus_a)
  );
  pwm_capture #(.PRESCALE(PS), .WIDTH(WB), .TIMEOUT(TB)) dut_b (
    .clk(clk), .reset(rst_b), .pwm_in(pwm_b), .bus(bus_b)
  );

  // Scoreboard: {strobe cycle[63:32], high[31:16], period[15:0]}.
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  int errors = 0;
  int checks = 0;

  // Reference model state per channel.
  bit armed[2];
  int rise_c[2];
  int high_len[2];
  int last_edge[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Driver: put level v on channel ch now (caller sits #1 after an edge) and
  // hold it for n cycles, updating the model for the edge just made.
  task automatic seg(input int ch, input bit v, input int n);
    int mx, lim;
    logic [W-1:0] e;
    mx  = (ch == 0) ? (1 << WA) - 1 : (1 << WB) - 1;
    lim = ((ch == 0) ? TA : TB) * PS + 2 * PS;
    if (cyc - last_edge[ch] > lim) armed[ch] = 1'b0;
    last_edge[ch] = cyc;
    if (v) begin
      if (armed[ch]) begin
        e = {32'(cyc + 4), 16'(sat(high_len[ch] / PS, mx)), 16'(sat((cyc - rise_c[ch]) / PS, mx))};
        if (ch == 0) exp_a.push_back(e);
        else         exp_b.push_back(e);
      end
      armed[ch]  = 1'b1;
      rise_c[ch] = cyc;
    end else begin
      high_len[ch] = cyc - rise_c[ch];
    end
    if (ch == 0) pwm_a = v;
    else         pwm_b = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitors: every strobe must match the head of its expected queue.
  logic         sv_prev_a = 1'b0, sv_prev_b = 1'b0;
  logic [W-1:0] ea, eb;
  always @(negedge clk) begin
    if (bus_a.sample_valid) begin
      if (exp_a.size() == 0) begin
        check("a_unexpected_strobe", 64'(bus_a.sample_valid), 64'(0));
      end else begin
        ea = exp_a.pop_front();
        check("a_strobe_cycle", 64'(cyc), 64'(ea[63:32]));
        check("a_high_ticks", 64'(bus_a.high_ticks), 64'(ea[31:16]));
        check("a_period_ticks", 64'(bus_a.period_ticks), 64'(ea[15:0]));
        check("a_stuck_clear_on_strobe", 64'(bus_a.level_stuck), 64'(0));
        check("a_back_to_back", 64'(sv_prev_a), 64'(0));
      end
    end
    sv_prev_a <= bus_a.sample_valid;
  end
  always @(negedge clk) begin
    if (bus_b.sample_valid) begin
      if (exp_b.size() == 0) begin
        check("b_unexpected_strobe", 64'(bus_b.sample_valid), 64'(0));
      end else begin
        eb = exp_b.pop_front();
        check("b_strobe_cycle", 64'(cyc), 64'(eb[63:32]));
        check("b_high_ticks", 64'(bus_b.high_ticks), 64'(eb[31:16]));
        check("b_period_ticks", 64'(bus_b.period_ticks), 64'(eb[15:0]));
        check("b_back_to_back", 64'(sv_prev_b), 64'(0));
      end
    end
    sv_prev_b <= bus_b.sample_valid;
  end

  // Directed sequence.
  initial begin
    int h, l;
    for (int i = 0; i < 2; i++) begin
      armed[i] = 1'b0; rise_c[i] = 0; high_len[i] = 0; last_edge[i] = 0;
    end
    rst_a = 1'b1; rst_b = 1'b1; pwm_a = 1'b0; pwm_b = 1'b0;
    wait_cycles(4);
    rst_a = 1'b0; rst_b = 1'b0;
    last_edge[0] = cyc; last_edge[1] = cyc;

    // Reset state.
    check("a_rst_high", 64'(bus_a.high_ticks), 64'(0));
    check("a_rst_period", 64'(bus_a.period_ticks), 64'(0));
    check("a_rst_valid", 64'(bus_a.sample_valid), 64'(0));
    check("a_rst_stuck", 64'(bus_a.level_stuck), 64'(0));
    check("a_rst_stuck_level", 64'(bus_a.stuck_level), 64'(0));
    check("a_rst_state", 64'(bus_a.fsm_state), 64'(0));
    check("b_rst_period", 64'(bus_b.period_ticks), 64'(0));
    check("b_rst_state", 64'(bus_b.fsm_state), 64'(0));
    wait_cycles(10);

    // Nominal duty 40/60.
    for (int i = 0; i < 4; i++) begin
      seg(0, 1'b1, 40);
      seg(0, 1'b0, 60);
    end
    check("a_nominal_high", 64'(bus_a.high_ticks), 64'(10));
    check("a_nominal_period", 64'(bus_a.period_ticks), 64'(25));

    // Stuck low after a valid cycle.
    seg(0, 1'b1, 40);
    seg(0, 1'b0, 395);
    check("a_stuck_low_early", 64'(bus_a.level_stuck), 64'(0));
    wait_cycles(20);
    check("a_stuck_low_set", 64'(bus_a.level_stuck), 64'(1));
    check("a_stuck_low_level", 64'(bus_a.stuck_level), 64'(0));
    check("a_stuck_low_hold_high", 64'(bus_a.high_ticks), 64'(10));
    check("a_stuck_low_hold_period", 64'(bus_a.period_ticks), 64'(25));
    check("a_stuck_low_state", 64'(bus_a.fsm_state), 64'(0));

    // Resume: first rise only arms, second publishes and clears the flag.
    seg(0, 1'b1, 40);
    seg(0, 1'b0, 60);
    check("a_resume_still_stuck", 64'(bus_a.level_stuck), 64'(1));
    seg(0, 1'b1, 40);
    seg(0, 1'b0, 60);
    check("a_resume_cleared", 64'(bus_a.level_stuck), 64'(0));

    // Stuck high.
    seg(0, 1'b1, 395);
    check("a_stuck_high_early", 64'(bus_a.level_stuck), 64'(0));
    wait_cycles(20);
    check("a_stuck_high_set", 64'(bus_a.level_stuck), 64'(1));
    check("a_stuck_high_level", 64'(bus_a.stuck_level), 64'(1));
    seg(0, 1'b0, 60);
    seg(0, 1'b1, 40);
    seg(0, 1'b0, 60);

    // Reset 20 cycles into a high phase.
    seg(0, 1'b1, 20);
    rst_a = 1'b1;
    wait_cycles(1);
    rst_a = 1'b0;
    armed[0] = 1'b0;
    last_edge[0] = cyc;
    check("a_midrst_high", 64'(bus_a.high_ticks), 64'(0));
    check("a_midrst_period", 64'(bus_a.period_ticks), 64'(0));
    check("a_midrst_valid", 64'(bus_a.sample_valid), 64'(0));
    check("a_midrst_stuck", 64'(bus_a.level_stuck), 64'(0));
    check("a_midrst_state", 64'(bus_a.fsm_state), 64'(0));
    wait_cycles(19);
    seg(0, 1'b0, 60);
    seg(0, 1'b1, 40);
    seg(0, 1'b0, 60);
    seg(0, 1'b1, 40);
    seg(0, 1'b0, 60);

    // Narrow 1-cycle pulse, 40-cycle period.
    for (int i = 0; i < 3; i++) begin
      seg(0, 1'b1, 1);
      seg(0, 1'b0, 39);
    end
    seg(0, 1'b1, 1);
    seg(0, 1'b0, 10);
    check("a_narrow_high", 64'(bus_a.high_ticks), 64'(0));
    check("a_narrow_period", 64'(bus_a.period_ticks), 64'(10));
    seg(0, 1'b1, 30);
    seg(0, 1'b0, 20);

    // Randomized periods.
    for (int i = 0; i < 20; i++) begin
      h = int'($urandom_range(1, 150));
      l = int'($urandom_range(1, 150));
      seg(0, 1'b1, h);
      seg(0, 1'b0, l);
    end
    seg(0, 1'b1, 10);
    seg(0, 1'b0, 10);

    // Saturation on the 4-bit instance: 80/120.
    for (int i = 0; i < 4; i++) begin
      seg(1, 1'b1, 80);
      seg(1, 1'b0, 120);
    end
    seg(1, 1'b1, 10);
    seg(1, 1'b0, 10);
    check("b_sat_high", 64'(bus_b.high_ticks), 64'(15));
    check("b_sat_period", 64'(bus_b.period_ticks), 64'(15));

    wait_cycles(10);
    check("a_pending_expected", 64'(exp_a.size()), 64'(0));
    check("b_pending_expected", 64'(exp_b.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
